wb_switch: RTL and testbench

- Parametrised single-master, NSLV-slave Wishbone interconnect for the Zet SoC.
- Replaces per-board hand-written arena decode and ack/data muxing with table-driven memory/IO window decode (wb_tga selects IO space).
- Registered request path and response capture per cycle.
- Interrupt-acknowledge vector response, unmapped-address default response, and a bus-timeout watchdog with error reporting.

---
 rtl/wb_switch.sv | 166 ++++++++++++++++
 tb/tb_wb_switch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_switch.sv
// rtl/wb_switch.sv - single-master NSLV-slave Wishbone interconnect with table decode and watchdog
module wb_switch #(
  parameter int                NSLV     = 4,
  parameter logic [8*NSLV-1:0] MEM_BASE = {8'hb8, 8'hc0, 8'hf0, 8'h00},
  parameter logic [8*NSLV-1:0] MEM_MASK = {8'hff, 8'hf0, 8'hf0, 8'h00},
  parameter logic [8*NSLV-1:0] IO_BASE  = {8'hb8, 8'he0, 8'h00, 8'h00},
  parameter logic [8*NSLV-1:0] IO_MASK  = {8'hff, 8'hfe, 8'h00, 8'h00},
  parameter int                TIMEOUT  = 255,
  parameter logic [15:0]       INTA_VEC = 16'd3
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [15:0]          m_dat_i,
  output logic [15:0]          m_dat_o,
  input  logic [19:1]          m_adr_i,
  input  logic                 m_we_i,
  input  logic                 m_tga_i,
  input  logic [1:0]           m_sel_i,
  input  logic                 m_stb_i,
  input  logic                 m_cyc_i,
  input  logic                 m_tgc_i,
  output logic                 m_ack_o,
  output logic [19:1]          s_adr_o,
  output logic [15:0]          s_dat_o,
  output logic                 s_we_o,
  output logic                 s_tga_o,
  output logic [1:0]           s_sel_o,
  output logic [NSLV-1:0]      s_stb_o,
  input  logic [16*NSLV-1:0]   s_dat_i,
  input  logic [NSLV-1:0]      s_ack_i,
  output logic                 timeout_o,
  output logic [7:0]           err_cnt_o,
  output logic [19:1]          err_adr_o
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [NSLV-1:0]   hit, hit_first;
  logic              hit_any, ack_sel;
  logic [15:0]       sel_dat;
  logic [15:0]       wd;
  logic              req, do_inta, do_unmapped, do_launch, do_abort, do_ack, do_expire;

  // window decode of the live master address; tga picks the IO or memory table
  always_comb begin
    hit = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (m_tga_i)
        hit[i] = (IO_MASK[8*i +: 8] != 8'h00) &&
                 ((m_adr_i[15:8] & IO_MASK[8*i +: 8]) == (IO_BASE[8*i +: 8] & IO_MASK[8*i +: 8]));
      else
        hit[i] = (MEM_MASK[8*i +: 8] != 8'h00) &&
                 ((m_adr_i[19:12] & MEM_MASK[8*i +: 8]) == (MEM_BASE[8*i +: 8] & MEM_MASK[8*i +: 8]));
    end
  end

  // isolating the lowest set bit gives lowest-index priority as a one-hot strobe
  assign hit_first = hit & (~hit + NSLV'(1));
  assign hit_any   = |hit;

  // response from the slave currently strobed; others are ignored
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (s_stb_o[i]) sel_dat = s_dat_i[16*i +: 16];
    end
  end

  assign ack_sel = |(s_ack_i & s_stb_o);

  // per-cycle actions; abort outranks ack, ack outranks the watchdog
  always_comb begin
    req         = (state == IDLE) && m_stb_i && m_cyc_i;
    do_inta     = req && m_tgc_i;
    do_unmapped = req && !m_tgc_i && !hit_any;
    do_launch   = req && !m_tgc_i && hit_any;
    do_abort    = (state == WAIT) && !m_cyc_i;
    do_ack      = (state == WAIT) && m_cyc_i && ack_sel;
    do_expire   = (state == WAIT) && m_cyc_i && !ack_sel && (wd == WD_LAST);
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = do_launch ? WAIT : DONE;
      WAIT:    if (do_abort) state_nxt = IDLE;
               else if (do_ack || do_expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  // request latch, slave strobe, completion data and watchdog
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      s_we_o    <= 1'b0;
      s_tga_o   <= 1'b0;
      s_sel_o   <= '0;
      s_stb_o   <= '0;
      m_dat_o   <= '0;
      m_ack_o   <= 1'b0;
      timeout_o <= 1'b0;
      wd        <= '0;
    end else begin
      m_ack_o   <= 1'b0;
      timeout_o <= 1'b0;
      if (req) begin
        s_adr_o <= m_adr_i;
        s_dat_o <= m_dat_i;
        s_we_o  <= m_we_i;
        s_tga_o <= m_tga_i;
        s_sel_o <= m_sel_i;
      end
      if (do_inta) begin
        m_dat_o <= INTA_VEC;
        m_ack_o <= 1'b1;
      end
      if (do_unmapped) begin
        m_dat_o <= 16'hffff;
        m_ack_o <= 1'b1;
      end
      if (do_launch) begin
        s_stb_o <= hit_first;
        wd      <= '0;
      end else if ((state == WAIT) && !do_abort && !do_ack && !do_expire) begin
        wd <= wd + 16'd1;
      end
      if (do_abort) s_stb_o <= '0;
      if (do_ack) begin
        if (!s_we_o) m_dat_o <= sel_dat;
        m_ack_o <= 1'b1;
        s_stb_o <= '0;
      end
      if (do_expire) begin
        m_dat_o   <= 16'hffff;
        m_ack_o   <= 1'b1;
        timeout_o <= 1'b1;
        s_stb_o   <= '0;
      end
    end
  end

  // saturating error counter and last error address
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      err_cnt_o <= '0;
      err_adr_o <= '0;
    end else if (do_unmapped || do_expire) begin
      if (err_cnt_o != 8'hff) err_cnt_o <= err_cnt_o + 8'd1;
      err_adr_o <= do_unmapped ? m_adr_i : s_adr_o;
    end
  end

endmodule

// File: tb/tb_wb_switch.sv
// tb/tb_wb_switch.sv - randomized self-checking bench for wb_switch against a window-range model
module tb_wb_switch;

  localparam int          NSLV = 4;
  localparam int          T    = 8;
  localparam logic [15:0] VEC  = 16'd3;

  // slot 0 is the rightmost byte; slave3 mem window overlaps slave2 to exercise priority
  localparam logic [31:0] MB = {8'hf8, 8'hf0, 8'hc0, 8'hb8};
  localparam logic [31:0] MM = {8'hf8, 8'hf0, 8'hf0, 8'hff};
  localparam logic [31:0] IB = {8'h00, 8'h00, 8'he0, 8'hb8};
  localparam logic [31:0] IM = {8'h00, 8'h00, 8'hfe, 8'hff};

  logic                 clk = 1'b0;
  logic                 wb_rst_i;
  logic [15:0]          m_dat_i, m_dat_o;
  logic [19:1]          m_adr_i;
  logic                 m_we_i, m_tga_i, m_stb_i, m_cyc_i, m_tgc_i, m_ack_o;
  logic [1:0]           m_sel_i;
  logic [19:1]          s_adr_o, err_adr_o;
  logic [15:0]          s_dat_o;
  logic                 s_we_o, s_tga_o, timeout_o;
  logic [1:0]           s_sel_o;
  logic [NSLV-1:0]      s_stb_o, s_ack_i;
  logic [16*NSLV-1:0]   s_dat_i;
  logic [7:0]           err_cnt_o;

  wb_switch #(
    .NSLV(NSLV), .MEM_BASE(MB), .MEM_MASK(MM), .IO_BASE(IB), .IO_MASK(IM),
    .TIMEOUT(T), .INTA_VEC(VEC)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_adr_i(m_adr_i), .m_we_i(m_we_i),
    .m_tga_i(m_tga_i), .m_sel_i(m_sel_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_tgc_i(m_tgc_i), .m_ack_o(m_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_tga_o(s_tga_o),
    .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .timeout_o(timeout_o), .err_cnt_o(err_cnt_o), .err_adr_o(err_adr_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  bit          checking = 0;
  int          ack_seen = 0;
  logic [3:0]  last_stb = '0;
  int          clocks;

  // expected DUT state after the most recent edge
  logic        exp_ack, exp_to;
  logic [3:0]  exp_stb;
  logic [15:0] exp_dat, exp_s_dat;
  logic [19:1] exp_s_adr, exp_err_adr;
  logic        exp_s_we, exp_s_tga;
  logic [1:0]  exp_s_sel;
  int          exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // address windows written as plain byte ranges, first listed slave wins
  function automatic int model_slave(input logic tga, input logic [19:0] ba);
    int a;
    if (tga) begin
      a = int'(ba[15:0]);
      if (a >= 'hB800 && a <= 'hB8FF) return 0;
      if (a >= 'hE000 && a <= 'hE1FF) return 1;
      return -1;
    end
    a = int'(ba);
    if (a >= 'hB8000 && a <= 'hB8FFF) return 0;
    if (a >= 'hC0000 && a <= 'hCFFFF) return 1;
    if (a >= 'hF0000 && a <= 'hFFFFF) return 2;
    return -1;
  endfunction

  function automatic logic [19:0] pick_addr(input logic tga);
    logic [19:0] r;
    r = 20'($urandom);
    if (tga) begin
      case ($urandom_range(0, 4))
        0: r[15:8] = 8'hb8;
        1: r[15:8] = 8'he0;
        2: r[15:8] = 8'he1;
        3: r[15:8] = 8'he2;
        default: ;
      endcase
    end else begin
      case ($urandom_range(0, 4))
        0: r[19:12] = 8'hb8;
        1: r[19:12] = 8'hc7;
        2: r[19:12] = 8'hf3;
        3: r[19:12] = 8'hfa;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic bump_err(input logic [19:1] a);
    if (exp_err < 255) exp_err++;
    exp_err_adr = a;
  endtask

  // every cycle: all outputs against the expected state
  always @(negedge clk) begin
    if (checking) begin
      check("m_ack_o", m_ack_o, exp_ack);
      check("timeout_o", timeout_o, exp_to);
      check("s_stb_o", s_stb_o, exp_stb);
      check("m_dat_o", m_dat_o, exp_dat);
      check("err_cnt_o", err_cnt_o, exp_err);
      check("err_adr_o", err_adr_o, exp_err_adr);
      check("s_adr_o", s_adr_o, exp_s_adr);
      check("s_dat_o", s_dat_o, exp_s_dat);
      check("s_ctl", {s_we_o, s_tga_o, s_sel_o}, {exp_s_we, exp_s_tga, exp_s_sel});
      if (m_ack_o === 1'b1) ack_seen++;
      if (s_stb_o !== '0) last_stb = s_stb_o;
    end
  end

  // one master transfer; d = slave ack delay after strobe (-1 never), abort_k = WAIT cycle to drop cyc
  task automatic run_txn(input logic tga, input logic [19:0] ba, input logic we, input logic [15:0] dat,
                         input logic [1:0] sel, input logic tgc, input int d, input int abort_k,
                         input logic hold, input logic [15:0] sdat, output int nclk);
    int slv;
    bit fin_ack;
    slv = model_slave(tga, ba);
    m_adr_i = ba[19:1]; m_dat_i = dat; m_we_i = we; m_tga_i = tga; m_sel_i = sel; m_tgc_i = tgc;
    m_stb_i = 1'b1; m_cyc_i = 1'b1;
    @(posedge clk); #1;
    nclk = 1;
    exp_s_adr = ba[19:1]; exp_s_dat = dat; exp_s_we = we; exp_s_tga = tga; exp_s_sel = sel;
    fin_ack = 1;
    if (tgc) begin
      exp_ack = 1'b1; exp_dat = VEC;
    end else if (slv < 0) begin
      exp_ack = 1'b1; exp_dat = 16'hffff; bump_err(ba[19:1]);
    end else begin
      exp_stb = 4'(1 << slv);
      for (int n = 0; n < T; n++) begin
        s_dat_i = {$urandom, $urandom};
        s_ack_i = 4'($urandom) & ~exp_stb;
        if (d == n) begin
          s_ack_i[slv] = 1'b1;
          s_dat_i[16*slv +: 16] = sdat;
        end
        if (abort_k == n) begin m_cyc_i = 1'b0; m_stb_i = 1'b0; end
        @(posedge clk); #1;
        nclk++;
        s_ack_i = '0;
        if (abort_k == n) begin exp_stb = '0; fin_ack = 0; break; end
        if (d == n) begin
          exp_ack = 1'b1; exp_stb = '0;
          if (!we) exp_dat = sdat;
          break;
        end
        if (n == T-1) begin
          exp_ack = 1'b1; exp_to = 1'b1; exp_stb = '0; exp_dat = 16'hffff; bump_err(ba[19:1]);
        end
      end
    end
    if (fin_ack) begin
      if (!hold) begin m_stb_i = 1'b0; m_cyc_i = 1'b0; end
      @(posedge clk); #1;
      nclk++;
      exp_ack = 1'b0; exp_to = 1'b0;
      m_stb_i = 1'b0; m_cyc_i = 1'b0;
    end
    m_tgc_i = 1'b0;
  endtask

  task automatic clear_exp();
    exp_ack = 0; exp_to = 0; exp_stb = '0; exp_dat = '0; exp_s_dat = '0; exp_s_adr = '0;
    exp_err_adr = '0; exp_s_we = 0; exp_s_tga = 0; exp_s_sel = '0; exp_err = 0;
  endtask

  // hard stop if the run ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // stimulus: reset, directed test-plan cases, random traffic, async reset, saturation
  initial begin
    int d, ak;
    logic tga, tgc;
    logic [19:0] ba;
    wb_rst_i = 1'b0; m_dat_i = '0; m_adr_i = '0; m_we_i = 0; m_tga_i = 0; m_sel_i = '0;
    m_stb_i = 0; m_cyc_i = 0; m_tgc_i = 0; s_dat_i = '0; s_ack_i = '0;
    clear_exp();
    repeat (2) @(posedge clk);
    #1 checking = 1;
    check("rst_ack", m_ack_o, 1'b0);
    check("rst_err_cnt", err_cnt_o, 8'd0);
    @(posedge clk); #1 wb_rst_i = 1'b1;

    check("model_mem_b8", model_slave(1'b0, 20'hB8000), 0);
    check("model_io_e1", model_slave(1'b1, 20'h0E134), 1);
    check("model_io_42", model_slave(1'b1, 20'h04200), 32'hffffffff);

    ack_seen = 0; last_stb = '0;
    run_txn(1'b0, 20'hB8000, 1'b0, 16'h0, 2'b11, 1'b0, 2, -1, 1'b0, 16'h0741, clocks);
    check("memrd_clocks", clocks, 5);
    check("memrd_dat", m_dat_o, 16'h0741);
    check("memrd_stb", last_stb, 4'b0001);
    check("memrd_acks", ack_seen, 1);

    ack_seen = 0; last_stb = '0;
    run_txn(1'b1, 20'h0E134, 1'b1, 16'h1234, 2'b11, 1'b0, 0, -1, 1'b0, 16'hbeef, clocks);
    check("iowr_clocks", clocks, 3);
    check("iowr_stb", last_stb, 4'b0010);
    check("iowr_sdat", s_dat_o, 16'h1234);
    check("iowr_we", s_we_o, 1'b1);
    check("iowr_dat_kept", m_dat_o, 16'h0741);
    check("iowr_err", err_cnt_o, 8'd0);

    ack_seen = 0; last_stb = '0;
    run_txn(1'b0, 20'h00000, 1'b0, 16'h0, 2'b00, 1'b1, -1, -1, 1'b0, 16'h0, clocks);
    check("inta_clocks", clocks, 2);
    check("inta_dat", m_dat_o, 16'd3);
    check("inta_no_stb", last_stb, 4'b0000);

    run_txn(1'b1, 20'h04200, 1'b0, 16'h0, 2'b11, 1'b0, -1, -1, 1'b0, 16'h0, clocks);
    check("unmap_clocks", clocks, 2);
    check("unmap_dat", m_dat_o, 16'hffff);
    check("unmap_err_cnt", err_cnt_o, 8'd1);
    check("unmap_err_adr", err_adr_o, 19'h02100);

    ack_seen = 0;
    run_txn(1'b0, 20'hC0000, 1'b0, 16'h0, 2'b11, 1'b0, -1, -1, 1'b0, 16'h0, clocks);
    check("tmo_clocks", clocks, 10);
    check("tmo_err_cnt", err_cnt_o, 8'd2);
    check("tmo_err_adr", err_adr_o, 19'h60000);
    check("tmo_acks", ack_seen, 1);

    ack_seen = 0;
    run_txn(1'b0, 20'hC0010, 1'b0, 16'h0, 2'b11, 1'b0, T-1, -1, 1'b1, 16'h5a5a, clocks);
    check("lateack_clocks", clocks, 10);
    check("lateack_dat", m_dat_o, 16'h5a5a);
    check("lateack_err", err_cnt_o, 8'd2);
    check("lateack_acks", ack_seen, 1);

    ack_seen = 0;
    run_txn(1'b0, 20'hB8002, 1'b0, 16'h0, 2'b11, 1'b0, 3, 1, 1'b0, 16'h1111, clocks);
    check("abort_clocks", clocks, 3);
    check("abort_acks", ack_seen, 0);
    check("abort_dat", m_dat_o, 16'h5a5a);

    last_stb = '0;
    run_txn(1'b0, 20'hF8000, 1'b0, 16'h0, 2'b01, 1'b0, 1, -1, 1'b0, 16'h2222, clocks);
    check("prio_stb", last_stb, 4'b0100);

    for (int i = 0; i < 200; i++) begin
      tga = 1'($urandom_range(0, 1));
      ba  = pick_addr(tga);
      tgc = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) d = -1;
      else d = int'($urandom_range(0, T-1));
      if ($urandom_range(0, 9) == 0) ak = int'($urandom_range(0, T-1));
      else ak = -1;
      run_txn(tga, ba, 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), tgc, d, ak,
              1'($urandom_range(0, 1)), 16'($urandom), clocks);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // asynchronous reset in the middle of WAIT
    m_adr_i = 19'h5C010; m_tga_i = 0; m_tgc_i = 0; m_we_i = 0; m_stb_i = 1; m_cyc_i = 1;
    @(posedge clk); #1;
    exp_s_adr = 19'h5C010; exp_s_dat = m_dat_i; exp_s_we = 0; exp_s_tga = 0; exp_s_sel = m_sel_i;
    exp_stb = 4'b0001;
    #2 wb_rst_i = 1'b0;
    #1;
    check("arst_stb", s_stb_o, 4'b0000);
    check("arst_dat", m_dat_o, 16'h0000);
    check("arst_adr", s_adr_o, 19'h0);
    check("arst_err", err_cnt_o, 8'd0);
    clear_exp();
    m_stb_i = 0; m_cyc_i = 0;
    @(posedge clk); #1 wb_rst_i = 1'b1;

    for (int i = 0; i < 300; i++) begin
      run_txn(1'b0, 20'hC1234, 1'b0, 16'h0, 2'b11, 1'b0, -1, -1, 1'b0, 16'h0, clocks);
    end
    check("sat_err_cnt", err_cnt_o, 8'd255);
    check("sat_err_adr", err_adr_o, 19'h6091A);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
